// File: rtl/poly_sched.sv
// poly_sched: two-requester front end for a shared 8-bit polynomial evaluator.
// Arbitrates between two requesters, captures the winner's {A,B,C,X} operands,
// then evaluates A*X^2 + B*X + C in five steps on one shared add/multiply ALU.
// The result and the requester index are returned over a valid/ready handshake.
// Build option: define POLY_SCHED_FIXED_PRIO_EN for fixed priority (requester 0
// always wins); the default build uses 1-bit round-robin arbitration.

module poly_sched #(
   parameter int unsigned DW = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [1:0]       ReqValid,
   input  logic [4*DW-1:0]  ReqData0,
   input  logic [4*DW-1:0]  ReqData1,
   output logic [1:0]       ReqReady,
   output logic [DW-1:0]    DataResult,
   output logic             ResultId,
   output logic             ResultValid,
   input  logic             ResultReady,
   output logic             Busy,
   output logic [3:0]       current_state
);

   localparam int unsigned SW = 4;

   typedef enum logic [SW-1:0] {
      ST_IDLE    = SW'(0),
      ST_CYCLE_0 = SW'(1),
      ST_CYCLE_1 = SW'(2),
      ST_CYCLE_2 = SW'(3),
      ST_CYCLE_3 = SW'(4),
      ST_CYCLE_4 = SW'(5),
      ST_DONE    = SW'(6)
   } state_e;

   state_e          state_q, state_d;

   logic [DW-1:0]   a_q, a_d;
   logic [DW-1:0]   b_q, b_d;
   logic [DW-1:0]   c_q, c_d;
   logic [DW-1:0]   x_q, x_d;
   logic [DW-1:0]   res_q, res_d;
   logic            id_q, id_d;

   logic            grant;
   logic            req_fire;

   logic            alu_mul;
   logic [DW-1:0]   alu_a;
   logic [DW-1:0]   alu_b;
   logic [DW-1:0]   alu_y;

`ifdef POLY_SCHED_FIXED_PRIO_EN

   // Fixed priority: requester 0 wins whenever it is valid.
   always_comb begin
      grant = ~ReqValid[0];
   end

`else

   logic            ptr_q, ptr_d;

   // Round-robin: the preferred requester wins a tie, a lone requester always wins.
   always_comb begin
      if (ReqValid == 2'b11) begin
         grant = ptr_q;
      end else begin
         grant = ReqValid[1];
      end
   end

   // Pointer moves to the other requester after every grant.
   always_comb begin
      ptr_d = ptr_q;
      if (req_fire) begin
         ptr_d = ~grant;
      end
   end

   // Pointer register; cleared by reset so requester 0 is preferred first.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

`endif

   // FSM state register.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: one cycle per compute step, hold in DONE until the result is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_fire) begin
               state_d = ST_CYCLE_0;
            end
         end
         ST_CYCLE_0: state_d = ST_CYCLE_1;
         ST_CYCLE_1: state_d = ST_CYCLE_2;
         ST_CYCLE_2: state_d = ST_CYCLE_3;
         ST_CYCLE_3: state_d = ST_CYCLE_4;
         ST_CYCLE_4: state_d = ST_DONE;
         ST_DONE: begin
            if (ResultReady) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: request accept only in IDLE, result valid only in DONE.
   always_comb begin
      ReqReady    = 2'b00;
      ResultValid = 1'b0;
      Busy        = 1'b1;
      case (state_q)
         ST_IDLE: begin
            Busy     = 1'b0;
            ReqReady = grant ? {ReqValid[1], 1'b0} : {1'b0, ReqValid[0]};
         end
         ST_DONE: begin
            ResultValid = 1'b1;
         end
         default: begin
            Busy = 1'b1;
         end
      endcase
   end

   assign req_fire = |ReqReady;

   // ALU operand selection for each compute step.
   always_comb begin
      alu_mul = 1'b0;
      alu_a   = a_q;
      alu_b   = x_q;
      case (state_q)
         ST_CYCLE_0, ST_CYCLE_1: begin
            alu_mul = 1'b1;
            alu_a   = a_q;
            alu_b   = x_q;
         end
         ST_CYCLE_2: begin
            alu_mul = 1'b1;
            alu_a   = b_q;
            alu_b   = x_q;
         end
         ST_CYCLE_3: begin
            alu_a = a_q;
            alu_b = b_q;
         end
         ST_CYCLE_4: begin
            alu_a = a_q;
            alu_b = c_q;
         end
         default: begin
            alu_mul = 1'b0;
         end
      endcase
   end

   // Shared ALU; results wrap modulo 2^DW.
   always_comb begin
      if (alu_mul) begin
         alu_y = alu_a * alu_b;
      end else begin
         alu_y = alu_a + alu_b;
      end
   end

   // Datapath next values: operand capture on accept, ALU write-back per step.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      c_d   = c_q;
      x_d   = x_q;
      res_d = res_q;
      id_d  = id_q;
      case (state_q)
         ST_IDLE: begin
            if (req_fire) begin
               {a_d, b_d, c_d, x_d} = grant ? ReqData1 : ReqData0;
               id_d = grant;
            end
         end
         ST_CYCLE_0, ST_CYCLE_1, ST_CYCLE_3: a_d   = alu_y;
         ST_CYCLE_2:                         b_d   = alu_y;
         ST_CYCLE_4:                         res_d = alu_y;
         default: begin
            res_d = res_q;
         end
      endcase
   end

   // Datapath registers; result and ID stay stable through DONE.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         x_q   <= '0;
         res_q <= '0;
         id_q  <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         c_q   <= c_d;
         x_q   <= x_d;
         res_q <= res_d;
         id_q  <= id_d;
      end
   end

   assign DataResult    = res_q;
   assign ResultId      = id_q;
   assign current_state = state_q;

endmodule

// File: tb/tb_poly_sched.sv
// Bench for poly_sched: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal results.

module tb_poly_sched;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [31:0] d0;
   logic [31:0] d1;
   logic [1:0]  req_ready;
   logic [7:0]  data_result;
   logic        result_id;
   logic        result_valid;
   logic        result_ready;
   logic        busy;
   logic [3:0]  cur_state;

   int total = 0;
   int bad   = 0;
   int xfers = 0;

`ifdef POLY_SCHED_FIXED_PRIO_EN
   localparam int RR1_VAL = 27;
   localparam int RR1_ID  = 0;
`else
   localparam int RR1_VAL = 21;
   localparam int RR1_ID  = 1;
`endif

   poly_sched #(.DW(8)) dut (
      .Clock         (clk),
      .Reset         (rst),
      .ReqValid      (req_valid),
      .ReqData0      (d0),
      .ReqData1      (d1),
      .ReqReady      (req_ready),
      .DataResult    (data_result),
      .ResultId      (result_id),
      .ResultValid   (result_valid),
      .ResultReady   (result_ready),
      .Busy          (busy),
      .current_state (cur_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input int a, input int b, input int c, input int x);
      return {8'(a), 8'(b), 8'(c), 8'(x)};
   endfunction

   // Reference value straight from the formula, reduced mod 256 at the end.
   function automatic int poly(input logic [31:0] p);
      int a, b, c, x;
      a = int'(p[31:24]);
      b = int'(p[23:16]);
      c = int'(p[15:8]);
      x = int'(p[7:0]);
      return (a * x * x + b * x + c) % 256;
   endfunction

   // Model: cycles elapsed since acceptance (0 = idle, 6 = result waiting).
   int          m_phase = 0;
   logic        m_ptr   = 1'b0;
   logic [7:0]  m_res   = 8'd0;
   logic        m_id    = 1'b0;
   int          m_pend  = 0;

   always @(negedge clk) begin
      logic [1:0] e_ready;
      logic       g;
`ifdef POLY_SCHED_FIXED_PRIO_EN
      g = req_valid[0] ? 1'b0 : 1'b1;
`else
      g = req_valid[m_ptr] ? m_ptr : ~m_ptr;
`endif
      e_ready = 2'b00;
      if (m_phase == 0 && req_valid[g]) e_ready[g] = 1'b1;

      chk("m_ready", 32'(req_ready),    32'(e_ready));
      chk("m_valid", 32'(result_valid), 32'(m_phase == 6));
      chk("m_busy",  32'(busy),         32'(m_phase != 0));
      chk("m_state", 32'(cur_state),    32'(m_phase));
      chk("m_data",  32'(data_result),  32'(m_res));
      chk("m_id",    32'(result_id),    32'(m_id));

      if (result_valid && result_ready) xfers++;

      if (rst) begin
         m_phase = 0;
         m_ptr   = 1'b0;
         m_res   = 8'd0;
         m_id    = 1'b0;
      end else if (m_phase == 0) begin
         if (e_ready != 2'b00) begin
            m_id    = g;
            m_ptr   = ~g;
            m_pend  = poly(g ? d1 : d0);
            m_phase = 1;
         end
      end else if (m_phase < 5) begin
         m_phase++;
      end else if (m_phase == 5) begin
         m_res   = 8'(m_pend);
         m_phase = 6;
      end else if (result_ready) begin
         m_phase = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a result; check latency when exp_lat > 0, value and ID.
   task automatic wait_result(input int exp_val, input int exp_id, input int exp_lat, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!result_valid && n < 20);
      chk({name, "_seen"}, 32'(result_valid), 32'd1);
      if (exp_lat > 0) chk({name, "_lat"}, n, exp_lat);
      chk({name, "_val"}, 32'(data_result), exp_val);
      chk({name, "_id"},  32'(result_id),   exp_id);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0;
      rst = 1'b1;
      req_valid = 2'b00;
      d0 = '0;
      d1 = '0;
      result_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("rst_state", 32'(cur_state),    0);
      chk("rst_valid", 32'(result_valid), 0);
      chk("rst_ready", 32'(req_ready),    0);
      chk("rst_busy",  32'(busy),         0);
      chk("rst_data",  32'(data_result),  0);
      step();
      rst = 1'b0;

      // Basic evaluation: 2*25 + 3*5 + 4 = 69.
      d0 = pack(2, 3, 4, 5);
      req_valid = 2'b01;
      @(negedge clk);
      chk("basic_ready", 32'(req_ready), 1);
      step();
      req_valid = 2'b00;
      wait_result(69, 0, 6, "basic");
      @(negedge clk);
      chk("basic_idle", 32'(cur_state), 0);

      // Wrap-around.
      step();
      d0 = pack(10, 0, 0, 10);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      wait_result(232, 0, 6, "wrap1");
      step();
      d1 = pack(255, 255, 255, 1);
      req_valid = 2'b10;
      step();
      req_valid = 2'b00;
      wait_result(253, 1, 6, "wrap2");

      // Simultaneous requests held continuously: 27 from req0, 21 from req1.
      step();
      d0 = pack(1, 2, 3, 4);
      d1 = pack(3, 1, 7, 2);
      req_valid = 2'b11;
      step();
      wait_result(27, 0, 6, "rr0");
      wait_result(RR1_VAL, RR1_ID, 7, "rr1");
      wait_result(27, 0, 7, "rr2");
      step();
      req_valid = 2'b00;

      // Backpressure: 7*3 + 1 = 22, held for 3 stalled cycles.
      result_ready = 1'b0;
      d0 = pack(0, 7, 1, 3);
      step();
      req_valid = 2'b01;
      step();
      req_valid = 2'b10;
      x0 = xfers;
      wait_result(22, 0, 6, "bp");
      chk("bp_ready0", 32'(req_ready), 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("bp_hold_val",   32'(data_result),  22);
         chk("bp_hold_id",    32'(result_id),    0);
         chk("bp_hold_ready", 32'(req_ready),    0);
         chk("bp_hold_valid", 32'(result_valid), 1);
      end
      step();
      result_ready = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("bp_xfer_valid", 32'(result_valid), 1);
      @(negedge clk);
      chk("bp_idle", 32'(cur_state), 0);
      chk("bp_one_xfer", xfers - x0, 1);

      // Reset mid-operation in CYCLE_2, with the pointer favouring req1 beforehand.
      step();
      d0 = pack(5, 5, 5, 5);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_state", 32'(cur_state), 3);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mr_state", 32'(cur_state),    0);
      chk("mr_valid", 32'(result_valid), 0);
      chk("mr_busy",  32'(busy),         0);
      chk("mr_data",  32'(data_result),  0);
      chk("mr_id",    32'(result_id),    0);
      chk("mr_ready", 32'(req_ready),    0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mr_no_valid", 32'(result_valid), 0);
      end
      step();
      d0 = pack(1, 2, 3, 4);
      d1 = pack(3, 1, 7, 2);
      req_valid = 2'b11;
      step();
      req_valid = 2'b00;
      wait_result(27, 0, 6, "post_rst");
      step();
      d1 = pack(3, 0, 0, 2);
      req_valid = 2'b10;
      step();
      req_valid = 2'b00;
      wait_result(12, 1, 6, "post_single");
      @(negedge clk);
      chk("end_idle", 32'(cur_state), 0);
      chk("xfer_total", xfers, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/poly_sched.md
# poly_sched

Two-requester scheduler for the shared 8-bit polynomial engine. Each requester submits a packed coefficient/operand set {A, B, C, X}. The block arbitrates between the requesters and captures the winner's operands into internal A/B/C/X registers. It then sequences a single shared add/multiply ALU through five compute cycles to produce A·X² + B·X + C, and returns the result with the requester ID over a valid/ready handshake. It replaces the Go-button load sequence with a bus-style front end, so several producers can share one evaluator.

## Interface
Parameters:
- DW, 8, data width of every operand, register and result.

Ports:
- Clock  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clock.
- ReqValid  in  2  per-requester request valid; bit i belongs to requester i.
- ReqData0  in  4·DW  requester 0 operands, {A[31:24], B[23:16], C[15:8], X[7:0]} for DW=8.
- ReqData1  in  4·DW  requester 1 operands, same packing as ReqData0.
- ReqReady  out  2  per-requester accept; at most one bit high in any cycle.
- DataResult  out  DW  evaluated polynomial, registered.
- ResultId  out  1  index of the requester whose result is on DataResult.
- ResultValid  out  1  result valid; held until accepted.
- ResultReady  in  1  consumer accept for the result.
- Busy  out  1  high in every state except IDLE.
- current_state  out  4  state encoding, for debug and bench visibility.

## Operation
States and encodings: IDLE=0, CYCLE_0=1, CYCLE_1=2, CYCLE_2=3, CYCLE_3=4, CYCLE_4=5, DONE=6. Encodings 7–15 are illegal and go to IDLE on the next edge.

IDLE:
- Grant is computed combinationally from ReqValid and the priority pointer.
- ReqReady[grant] = 1 only if ReqValid[grant] = 1.
- On ReqValid[i] & ReqReady[i], capture A, B, C, X from ReqData_i, latch ResultId ← i, update the pointer, and go to CYCLE_0.

Compute sequence (one cycle each; ALU ops wrap mod 2^DW after every step):
- CYCLE_0: A ← A·X.
- CYCLE_1: A ← A·X.
- CYCLE_2: B ← B·X.
- CYCLE_3: A ← A + B.
- CYCLE_4: DataResult ← A + C, then go to DONE.

DONE:
- ResultValid = 1.
- On ResultReady = 1, go to IDLE.
- ReqReady = 0.

Arbitration:
- Round-robin with a 1-bit pointer naming the preferred requester.
- Pointer reset value is 0, so requester 0 is preferred first.
- After a grant to i, the pointer becomes ~i.
- If only one requester is valid, it wins regardless of the pointer.
- A requester may drop ReqValid before it is granted; no request is ever recorded in that case.

Reset:
- Reset takes priority over everything else.
- Reset in any state, including mid-compute or in DONE, returns the block to IDLE and clears the pointer.
- Any in-flight computation is discarded, and no ResultValid pulse is produced for it.

## Timing
Reset values:
- Registers: DataResult=0, ResultId=0, internal A/B/C/X=0.
- Outputs: ResultValid=0, ReqReady=0, Busy=0, current_state=0.

Latency:
- The request is accepted at edge k.
- The block is in CYCLE_0 during cycle k+1 and in CYCLE_4 during cycle k+5.
- ResultValid is high from cycle k+6 onward.
- Acceptance to ResultValid is therefore 6 cycles.

Result handshake:
- DataResult and ResultId are stable while ResultValid = 1.
- When ResultReady is already high on entry to DONE, the result transfers in that one cycle. IDLE follows at k+7.

Throughput:
- The earliest next acceptance is in the IDLE cycle after DONE.
- Maximum rate is one result per 7 cycles.

ReqReady timing:
- ReqReady is combinational from ReqValid, the state and the pointer.
- It never depends on ResultReady.

## Configuration
- POLY_SCHED_FIXED_PRIO_EN defined: fixed priority. Requester 0 always wins when both are valid; the pointer register is not implemented.
- POLY_SCHED_FIXED_PRIO_EN undefined (default): round-robin as described in Operation.
- All other behaviour and timing are identical in both configurations.

## Test plan
- Basic evaluation: after reset, ReqValid=01 with ReqData0 = A=2, B=3, C=4, X=5 and ResultReady=1. Expect ReqReady=01 on the accept cycle, ResultValid 6 cycles later, DataResult=69, ResultId=0, and IDLE one cycle after that.
- Wrap-around: A=10, B=0, C=0, X=10. Expect DataResult=232 (1000 mod 256 after the second multiply). Also A=255, B=255, C=255, X=1 gives DataResult=253.
- Simultaneous requests: ReqValid=11 held continuously, each requester with distinct operands. Expect grants in the order req0, req1, req0, each result carrying the matching ResultId. With POLY_SCHED_FIXED_PRIO_EN defined, req0 wins every time.
- Backpressure: ResultReady=0 for 3 cycles after ResultValid rises, then 1. Expect DataResult and ResultId unchanged throughout the stall, ReqReady=00 throughout, and exactly one transfer.
- Reset mid-operation: assert Reset during CYCLE_2. Expect current_state=0 on the next edge, all outputs at their reset values, and no ResultValid. The next request computes correctly, and requester 0 wins the next contention.
